instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Registered instruction-decode stage between fetch and execute in the FP RISC-V core.
- Classifies each 32-bit instruction by format, including the F-extension formats.
- Extracts the register fields and the sign-extended immediate, and flags illegal encodings.
- Buffers decoded results in a small FIFO with valid/ready handshakes on both sides, plus flush and an illegal-instruction counter.

Parameters:
- XLEN, 32, width of PC and immediate datapath.
- FP_EN, 1, 1 = F-extension opcodes legal; 0 = they decode as illegal.
- DEPTH, 2, decoded-entry FIFO depth; power of two, >= 2.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all buffered and incoming entries this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept (FIFO not full).
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes head.
- out_type  out  instr_type_enum  decoded format.
- out_rd, out_rs1, out_rs2, out_rs3  out  5 each  register fields (rs3 = instr[31:27]).
- out_imm  out  XLEN  sign-extended immediate; 0 for R/R4.
- out_pc  out  XLEN  PC of head entry.
- out_illegal  out  1  head entry is illegal.
- illegal_cnt  out  CNT_W  count of illegal instructions accepted.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_type=INSTR_TYPE_UNKNOWN, all other outputs 0, FIFO empty, illegal_cnt=0.
- Reset is asserted asynchronously in any state; it discards all FIFO contents.
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready && !flush.
- in_ready = (count < DEPTH), derived from registered count only; it has no combinational path from out_ready.
- Latency: an instruction pushed at edge N is visible on the out_* ports in the cycle after edge N if the FIFO was empty. Zero-bubble streaming: a full-rate push/pop sustains 1 instr/cycle.
- Push and pop in the same cycle: count is unchanged, pointers both advance, wrap modulo DEPTH.
- Full: in_ready=0 and no push, even if a pop occurs that cycle. in_ready rises the cycle after the pop.
- Empty: out_valid=0; out_* hold their last values, which are don't-care for the checker.
- Flush: at the next edge count=0 and pointers=0. The flush-cycle input is dropped and not counted. out_valid=0 and in_ready=1 in the following cycle.
- Decode is combinational on in_instr and registered into the FIFO entry.
- Opcode classification (instr[6:0]):
  - 0110011 -> R.
  - 0010011, 0000011, 1100111 (JALR), 1110011 (SYSTEM) -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111 (LUI), 0010111 (AUIPC) -> U.
  - 1101111 -> J.
  - With FP_EN=1: 0000111 -> I, 0100111 -> S, 1010011 -> R, and 1000011/1000111/1001011/1001111 -> R4.
  - Anything else -> UNKNOWN.
- Illegal = (type==UNKNOWN) || (instr[1:0]!=2'b11) || (FP opcode && FP_EN==0). Illegal entries are still pushed, with out_type=INSTR_TYPE_UNKNOWN.
- Immediates, sign-extended to XLEN from instr[31]:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Register fields are extracted unconditionally regardless of type.
- illegal_cnt increments by 1 on each push of an illegal entry and saturates at 2^CNT_W-1. It is cleared only by rst, not by flush.

Decomposition:
- Shared package:
  - instr_type_enum, extended with INSTR_TYPE_R4 while keeping the existing encodings.
  - Opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_LOAD_FP, OPC_STORE_FP, OPC_OP_FP, OPC_FMADD..OPC_FNMADD).
  - A decoded_instr_t packed struct holding type, rd, rs1, rs2, rs3, imm, pc and illegal.
- Sub-module: instr_imm_gen, purely combinational (instr, type -> imm). The FIFO stays inline.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle: out_valid=1, type=I, rd=1, rs1=0, imm=5, illegal=0.
- Push 0xFE208EE3 (beq, negative offset) -> type=B, rs1=1, rs2=2, imm=0xFFFFFFFC.
- FP_EN=1, push 0x1020F1C3 (fmadd.s) -> type=R4, rs3=2, imm=0.
- FP_EN=0, same instruction -> type=UNKNOWN, illegal=1, illegal_cnt=1.
- Backpressure:
  - Hold out_ready=0 and push 3 instrs with DEPTH=2 -> in_ready=0 after 2 pushes, and the 3rd is held by the source.
  - Then raise out_ready -> entries pop in order with no loss or duplication.
- Flush with 2 entries buffered and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the dropped input does not appear. Separately, drive 2^CNT_W+3 illegal pushes -> illegal_cnt saturates at all-ones.

Source files
------------

// File: rtl/instr_decode_stage_pkg.sv
// Shared types and constants for the instruction-decode stage.
//   instr_type_enum : instruction format (R4 added for fused FP multiply-add)
//   OPC_*           : 7-bit major opcodes, base ISA and F extension
//   decoded_instr_t : one decoded FIFO entry
//   DECODED_RST     : entry value used at reset (type UNKNOWN, all else zero)
package instr_decode_stage_pkg;

  // Storage width for imm/pc inside a decoded entry; the stage supports XLEN up to this.
  localparam int unsigned DEC_XLEN = 32;

  typedef enum logic [2:0] {
    INSTR_TYPE_UNKNOWN = 3'd0,
    INSTR_TYPE_R       = 3'd1,
    INSTR_TYPE_I       = 3'd2,
    INSTR_TYPE_S       = 3'd3,
    INSTR_TYPE_B       = 3'd4,
    INSTR_TYPE_U       = 3'd5,
    INSTR_TYPE_J       = 3'd6,
    INSTR_TYPE_R4      = 3'd7
  } instr_type_enum;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;

  typedef struct packed {
    instr_type_enum      itype;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rs3;
    logic [DEC_XLEN-1:0] imm;
    logic [DEC_XLEN-1:0] pc;
    logic                illegal;
  } decoded_instr_t;

  localparam decoded_instr_t DECODED_RST = '{
    itype:   INSTR_TYPE_UNKNOWN,
    rd:      5'd0,
    rs1:     5'd0,
    rs2:     5'd0,
    rs3:     5'd0,
    imm:     '0,
    pc:      '0,
    illegal: 1'b0
  };

  function automatic logic is_fp_opcode(input logic [6:0] opc);
    return (opc == OPC_LOAD_FP) || (opc == OPC_STORE_FP) || (opc == OPC_OP_FP) ||
           (opc == OPC_FMADD)   || (opc == OPC_FMSUB)    || (opc == OPC_FNMSUB) ||
           (opc == OPC_FNMADD);
  endfunction

endpackage

// File: rtl/instr_imm_gen.sv
// Combinational immediate generator.
//   i_instr : instruction bits [31:7] (opcode bits are not needed)
//   i_type  : decoded format; R, R4 and UNKNOWN yield zero
//   o_imm   : immediate sign-extended from instr[31] to XLEN
module instr_imm_gen
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     i_instr,
  input  instr_type_enum  i_type,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (i_type)
      INSTR_TYPE_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      INSTR_TYPE_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      INSTR_TYPE_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                               i_instr[11:8], 1'b0};
      INSTR_TYPE_U: w_imm32 = {i_instr[31:12], 12'b0};
      INSTR_TYPE_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                               i_instr[30:21], 1'b0};
      default:      w_imm32 = '0;
    endcase
  end

  // Signed cast sign-extends when XLEN exceeds 32.
  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage between fetch and execute.
//   clk, rst (async, active high), flush
//   in_valid/in_ready/in_instr/in_pc    : fetch side
//   out_valid/out_ready/out_*           : execute side, head of a DEPTH-entry FIFO
//   illegal_cnt                         : saturating count of pushed illegal entries
// Decode is combinational on in_instr and captured into the FIFO on push.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned FP_EN = 1,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output instr_type_enum   out_type,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rs3,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  // ---------------- decode ----------------
  logic [6:0]      w_opc;
  logic            w_fp_opc;
  logic            w_illegal;
  instr_type_enum  w_type_raw;
  instr_type_enum  w_type;
  logic [XLEN-1:0] w_imm;
  decoded_instr_t  w_entry;

  always_comb begin
    w_opc      = in_instr[6:0];
    w_fp_opc   = is_fp_opcode(w_opc);
    w_type_raw = INSTR_TYPE_UNKNOWN;
    case (w_opc)
      OPC_OP:                                  w_type_raw = INSTR_TYPE_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: w_type_raw = INSTR_TYPE_I;
      OPC_STORE:                               w_type_raw = INSTR_TYPE_S;
      OPC_BRANCH:                              w_type_raw = INSTR_TYPE_B;
      OPC_LUI, OPC_AUIPC:                      w_type_raw = INSTR_TYPE_U;
      OPC_JAL:                                 w_type_raw = INSTR_TYPE_J;
      OPC_LOAD_FP:  if (FP_EN != 0)            w_type_raw = INSTR_TYPE_I;
      OPC_STORE_FP: if (FP_EN != 0)            w_type_raw = INSTR_TYPE_S;
      OPC_OP_FP:    if (FP_EN != 0)            w_type_raw = INSTR_TYPE_R;
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD:
                    if (FP_EN != 0)            w_type_raw = INSTR_TYPE_R4;
      default:                                 w_type_raw = INSTR_TYPE_UNKNOWN;
    endcase
    w_illegal = (w_type_raw == INSTR_TYPE_UNKNOWN) || (in_instr[1:0] != 2'b11) ||
                (w_fp_opc && (FP_EN == 0));
    // Illegal entries are still buffered but always report UNKNOWN (and thus imm 0).
    w_type    = w_illegal ? INSTR_TYPE_UNKNOWN : w_type_raw;
  end

  instr_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .i_instr (in_instr[31:7]),
    .i_type  (w_type),
    .o_imm   (w_imm)
  );

  always_comb begin
    w_entry         = DECODED_RST;
    w_entry.itype   = w_type;
    w_entry.rd      = in_instr[11:7];
    w_entry.rs1     = in_instr[19:15];
    w_entry.rs2     = in_instr[24:20];
    w_entry.rs3     = in_instr[31:27];
    w_entry.imm     = DEC_XLEN'(w_imm);
    w_entry.pc      = DEC_XLEN'(in_pc);
    w_entry.illegal = w_illegal;
  end

  // ---------------- FIFO ----------------
  decoded_instr_t    r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_count;
  logic [CNT_W-1:0]  r_ill_cnt;
  logic              w_push;
  logic              w_pop;
  decoded_instr_t    w_head;

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (r_count < FCNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= DECODED_RST;
      end
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ill_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
      end
      if (w_push && w_entry.illegal && (r_ill_cnt != '1)) begin
        r_ill_cnt <= r_ill_cnt + CNT_W'(1);
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        // Power-of-two DEPTH lets the pointers wrap naturally.
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + FCNT_W'(1);
          2'b01:   r_count <= r_count - FCNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign out_type    = w_head.itype;
  assign out_rd      = w_head.rd;
  assign out_rs1     = w_head.rs1;
  assign out_rs2     = w_head.rs2;
  assign out_rs3     = w_head.rs3;
  assign out_imm     = XLEN'(w_head.imm);
  assign out_pc      = XLEN'(w_head.pc);
  assign out_illegal = w_head.illegal;
  assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage. Two instances share stimulus:
// u_dut_fp (FP_EN=1, CNT_W=16) and u_dut_nf (FP_EN=0, CNT_W=4, small enough to saturate).
module tb_instr_decode_stage;
  import instr_decode_stage_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W_NF = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_ready;

  logic            fp_in_ready, fp_out_valid, fp_out_illegal;
  instr_type_enum  fp_out_type;
  logic [4:0]      fp_out_rd, fp_out_rs1, fp_out_rs2, fp_out_rs3;
  logic [XLEN-1:0] fp_out_imm, fp_out_pc;
  logic [15:0]     fp_illegal_cnt;

  logic            nf_in_ready, nf_out_valid, nf_out_illegal;
  instr_type_enum  nf_out_type;
  logic [4:0]      nf_out_rd, nf_out_rs1, nf_out_rs2, nf_out_rs3;
  logic [XLEN-1:0] nf_out_imm, nf_out_pc;
  logic [CNT_W_NF-1:0] nf_illegal_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(
    .XLEN(XLEN), .FP_EN(1), .DEPTH(2), .CNT_W(16)
  ) u_dut_fp (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(fp_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(fp_out_valid), .out_ready(out_ready), .out_type(fp_out_type),
    .out_rd(fp_out_rd), .out_rs1(fp_out_rs1), .out_rs2(fp_out_rs2), .out_rs3(fp_out_rs3),
    .out_imm(fp_out_imm), .out_pc(fp_out_pc), .out_illegal(fp_out_illegal),
    .illegal_cnt(fp_illegal_cnt)
  );

  instr_decode_stage #(
    .XLEN(XLEN), .FP_EN(0), .DEPTH(2), .CNT_W(CNT_W_NF)
  ) u_dut_nf (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(nf_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(nf_out_valid), .out_ready(out_ready), .out_type(nf_out_type),
    .out_rd(nf_out_rd), .out_rs1(nf_out_rs1), .out_rs2(nf_out_rs2), .out_rs3(nf_out_rs3),
    .out_imm(nf_out_imm), .out_pc(nf_out_pc), .out_illegal(nf_out_illegal),
    .illegal_cnt(nf_illegal_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v < max_v) ? v + 1 : max_v;
  endfunction

  typedef struct {
    logic [31:0]    instr;
    instr_type_enum ty;
    logic [31:0]    imm;
    logic           ill_fp;
    logic           ill_nf;
  } vec_t;

  vec_t        vq[$];
  int unsigned exp_cnt_fp;
  int unsigned exp_cnt_nf;
  logic [31:0] pc;
  logic [31:0] iw;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    exp_cnt_fp = 0; exp_cnt_nf = 0;

    vq.push_back('{32'h00500093, INSTR_TYPE_I,       32'h00000005, 1'b0, 1'b0}); // addi x1,x0,5
    vq.push_back('{32'hFE208EE3, INSTR_TYPE_B,       32'hFFFFFFFC, 1'b0, 1'b0}); // beq -4
    vq.push_back('{32'h00112623, INSTR_TYPE_S,       32'h0000000C, 1'b0, 1'b0}); // sw x1,12(x2)
    vq.push_back('{32'h123450B7, INSTR_TYPE_U,       32'h12345000, 1'b0, 1'b0}); // lui
    vq.push_back('{32'h008000EF, INSTR_TYPE_J,       32'h00000008, 1'b0, 1'b0}); // jal x1,8
    vq.push_back('{32'h1020F1C3, INSTR_TYPE_R4,      32'h00000000, 1'b0, 1'b1}); // fmadd.s
    vq.push_back('{32'h0040A087, INSTR_TYPE_I,       32'h00000004, 1'b0, 1'b1}); // flw
    vq.push_back('{32'h002081B3, INSTR_TYPE_R,       32'h00000000, 1'b0, 1'b0}); // add
    vq.push_back('{32'h00000000, INSTR_TYPE_UNKNOWN, 32'h00000000, 1'b1, 1'b1}); // all-zero
    vq.push_back('{32'h00500090, INSTR_TYPE_UNKNOWN, 32'h00000000, 1'b1, 1'b1}); // low bits 00
    vq.push_back('{32'hFFF00093, INSTR_TYPE_I,       32'hFFFFFFFF, 1'b0, 1'b0}); // addi -1

    // Reset state
    tick(); tick();
    check("rst_in_ready",  fp_in_ready, 1);
    check("rst_out_valid", fp_out_valid, 0);
    check("rst_out_type",  fp_out_type, INSTR_TYPE_UNKNOWN);
    check("rst_out_rd",    fp_out_rd, 0);
    check("rst_out_rs3",   fp_out_rs3, 0);
    check("rst_out_imm",   fp_out_imm, 0);
    check("rst_out_pc",    fp_out_pc, 0);
    check("rst_out_ill",   fp_out_illegal, 0);
    check("rst_cnt_fp",    fp_illegal_cnt, 0);
    check("rst_cnt_nf",    nf_illegal_cnt, 0);
    rst = 1'b0;

    // Directed decode vectors, streamed at full rate with out_ready high
    out_ready = 1'b1;
    pc = 32'h0000_1000;
    foreach (vq[k]) begin
      in_valid = 1'b1; in_instr = vq[k].instr; in_pc = pc;
      tick();
      in_valid = 1'b0;
      iw = vq[k].instr;
      if (vq[k].ill_fp) exp_cnt_fp = exp_cnt_fp + 1;
      if (vq[k].ill_nf) exp_cnt_nf = sat_inc(exp_cnt_nf, (1 << CNT_W_NF) - 1);
      check($sformatf("v%0d_valid", k), fp_out_valid, 1);
      check($sformatf("v%0d_type", k),  fp_out_type, vq[k].ty);
      check($sformatf("v%0d_imm", k),   fp_out_imm, vq[k].imm);
      check($sformatf("v%0d_ill", k),   fp_out_illegal, vq[k].ill_fp);
      check($sformatf("v%0d_rd", k),    fp_out_rd, iw[11:7]);
      check($sformatf("v%0d_rs1", k),   fp_out_rs1, iw[19:15]);
      check($sformatf("v%0d_rs2", k),   fp_out_rs2, iw[24:20]);
      check($sformatf("v%0d_rs3", k),   fp_out_rs3, iw[31:27]);
      check($sformatf("v%0d_pc", k),    fp_out_pc, pc);
      check($sformatf("v%0d_cnt_fp", k), fp_illegal_cnt, exp_cnt_fp);
      check($sformatf("v%0d_nf_type", k), nf_out_type,
            vq[k].ill_nf ? INSTR_TYPE_UNKNOWN : vq[k].ty);
      check($sformatf("v%0d_nf_ill", k), nf_out_illegal, vq[k].ill_nf);
      check($sformatf("v%0d_cnt_nf", k), nf_illegal_cnt, exp_cnt_nf);
      pc = pc + 4;
    end
    tick();
    check("drain_valid", fp_out_valid, 0);

    // Backpressure: DEPTH=2 fills, third instruction is held by the source
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h2000; tick();
    in_instr = 32'h00200113; in_pc = 32'h2004; tick();
    check("bp_full_ready", fp_in_ready, 0);
    check("bp_full_valid", fp_out_valid, 1);
    check("bp_head_a",     fp_out_pc, 32'h2000);
    in_instr = 32'h00300193; in_pc = 32'h2008; tick(); tick();
    check("bp_hold_ready", fp_in_ready, 0);
    check("bp_hold_head",  fp_out_pc, 32'h2000);
    out_ready = 1'b1; tick();
    check("bp_pop1_head",  fp_out_pc, 32'h2004);
    check("bp_pop1_ready", fp_in_ready, 1);
    tick();
    check("bp_pop2_head",  fp_out_pc, 32'h2008);
    check("bp_pop2_rd",    fp_out_rd, 3);
    check("bp_pop2_valid", fp_out_valid, 1);
    in_valid = 1'b0; tick();
    check("bp_empty",      fp_out_valid, 0);

    // Flush with two entries buffered and an illegal input presented
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h3000; tick();
    in_instr = 32'h00200113; in_pc = 32'h3004; tick();
    in_instr = 32'h00000000; in_pc = 32'h3008; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid",  fp_out_valid, 0);
    check("fl_ready",  fp_in_ready, 1);
    check("fl_cnt_fp", fp_illegal_cnt, exp_cnt_fp);
    check("fl_cnt_nf", nf_illegal_cnt, exp_cnt_nf);
    out_ready = 1'b1; tick();
    check("fl_no_ghost", fp_out_valid, 0);
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h3010; tick();
    in_valid = 1'b0;
    check("fl_after_valid", fp_out_valid, 1);
    check("fl_after_pc",    fp_out_pc, 32'h3010);
    tick();

    // Illegal counter saturation on the narrow-counter instance
    in_valid = 1'b1; in_instr = 32'h00000000;
    for (int i = 0; i < (1 << CNT_W_NF) + 3; i++) begin
      in_pc = 32'h4000 + 32'(i * 4);
      tick();
      exp_cnt_fp = exp_cnt_fp + 1;
      exp_cnt_nf = sat_inc(exp_cnt_nf, (1 << CNT_W_NF) - 1);
    end
    in_valid = 1'b0;
    check("sat_cnt_nf", nf_illegal_cnt, {CNT_W_NF{1'b1}});
    check("sat_cnt_nf_model", nf_illegal_cnt, exp_cnt_nf);
    check("sat_cnt_fp", fp_illegal_cnt, exp_cnt_fp);
    tick();

    // Asynchronous reset between clock edges discards buffered entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h5000; tick();
    in_valid = 1'b0;
    check("ar_pre_valid", fp_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid",  fp_out_valid, 0);
    check("ar_ready",  fp_in_ready, 1);
    check("ar_type",   fp_out_type, INSTR_TYPE_UNKNOWN);
    check("ar_cnt_fp", fp_illegal_cnt, 0);
    check("ar_cnt_nf", nf_illegal_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    check("ar_post_valid", fp_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
